adder_seq: RTL and testbench

Multi-cycle sequencer that computes a WIDTH-bit add (A + B + C_in) by time-sharing one SLICE-bit `full_adder` over WIDTH/SLICE clock cycles. A registered carry links consecutive slices. The block uses a valid/ready handshake on both input and output. It sits between operand producers and consumers when a full-width combinational ripple adder is too large or too slow for the target clock.

---
 rtl/adder_seq_pkg.sv | 26 ++
 rtl/full_adder.sv | 15 +
 rtl/adder_seq.sv | 147 ++++++++++++++
 tb/tb_adder_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and elaboration-time helpers for the slice-serial adder.
package adder_seq_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices needed to cover the full operand width.
  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice counter width; never narrower than one bit so NSLICE=1 still works.
  function automatic int calc_cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  // Legal geometry: slice width divides the operand width and fits inside it.
  function automatic bit cfg_ok(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// SLICE-bit full adder shared across every slice of the sequencer.
module full_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic             c_out,
  output logic [SLICE-1:0] sum
);

  // Widen by one bit so the carry falls out of the top of the addition.
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};

endmodule

// File: rtl/adder_seq.sv
// Slice-serial WIDTH-bit adder: one SLICE-bit full_adder reused over
// WIDTH/SLICE cycles with a registered carry between slices, valid/ready
// handshake on both sides.
// Optional feature: define ADDSEQ_SUB_EN to add the `sub` port (A - B).
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
`ifdef ADDSEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             busy
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int CNT_W  = calc_cnt_w(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  if (!cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $error("adder_seq: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             run_last;
  logic [SLICE-1:0] slice_sum;
  logic             slice_c_out;
  logic [WIDTH-1:0] sum_sr_d;
  logic [WIDTH-1:0] b_sel;
  logic             c_sel;

  // The single shared slice adder always sees the low slice of the operands.
  full_adder #(.SLICE(SLICE)) u_fa (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .c_in (carry_q),
    .c_out(slice_c_out),
    .sum  (slice_sum)
  );

  // Operand/carry selection at acceptance; subtract inverts B and forces carry-in.
`ifdef ADDSEQ_SUB_EN
  assign b_sel = sub ? ~B : B;
  assign c_sel = sub ? 1'b1 : C_in;
`else
  assign b_sel = B;
  assign c_sel = C_in;
`endif

  // New slice sum enters at the top while earlier slices move toward bit 0.
  always_comb begin
    sum_sr_d = sum_sr_q >> SLICE;
    sum_sr_d[WIDTH-1 -: SLICE] = slice_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    run_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_CNT) begin
          run_last = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, process one slice per RUN cycle,
  // publish the result on the last slice.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset as well as the control state, so
    // an aborted operation can never leak a partial sum onto S.
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      S        <= '0;
      C_out    <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments everywhere in sequential logic, so every
      // register samples the pre-edge value of the others.
      a_q     <= A;
      b_q     <= b_sel;
      carry_q <= c_sel;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> SLICE;
      b_q      <= b_q >> SLICE;
      carry_q  <= slice_c_out;
      sum_sr_q <= sum_sr_d;
      cnt_q    <= cnt_q + 1'b1;
      if (run_last) begin
        S     <= sum_sr_d;
        C_out <= slice_c_out;
      end
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Directed self-checking bench for adder_seq (WIDTH=32, SLICE=8).
module tb_adder_seq;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             C_in = 1'b0;
`ifdef ADDSEQ_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  adder_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .C_in     (C_in),
`ifdef ADDSEQ_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .C_out    (C_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Full operation: accept, count latency, check result, drain, check hold.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin, input logic sb,
                        input logic [WIDTH-1:0] exp_s, input logic exp_c);
    @(negedge clk);
    A = a; B = b; C_in = cin; in_valid = 1'b1;
`ifdef ADDSEQ_SUB_EN
    sub = sb;
`endif
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the result must not depend on them.
    in_valid = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678; C_in = ~cin;
    for (int i = 1; i <= NSLICE; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== (i == NSLICE)) begin
        tests_failed++;
        $display("FAIL %s out_valid after edge E%0d: got %b want %b",
                 name, i, out_valid, (i == NSLICE));
      end
    end
    tests_run++;
    if (S !== exp_s || C_out !== exp_c || in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s result: got S=%h C_out=%b in_ready=%b busy=%b want S=%h C_out=%b in_ready=0 busy=1",
               name, S, C_out, in_ready, busy, exp_s, exp_c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s drain: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (S !== exp_s || C_out !== exp_c) begin
      tests_failed++;
      $display("FAIL %s hold in IDLE: got S=%h C_out=%b want S=%h C_out=%b",
               name, S, C_out, exp_s, exp_c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        S !== 32'h0 || C_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset state: got in_ready=%b out_valid=%b busy=%b S=%h C_out=%b want 1 0 0 0 0",
               in_ready, out_valid, busy, S, C_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op("zero",       32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    run_op("all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_op("slice_carry",32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0);
    run_op("mixed",      32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0);
    run_op("wrap",       32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_s;
    exp_s = 32'h0102_0305;
    @(negedge clk);
    A = 32'h0101_0102; B = 32'h0001_0203; C_in = 1'b0; in_valid = 1'b1;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;
    // Keep in_valid high throughout: it must be ignored outside IDLE.
    repeat (NSLICE) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== exp_s || C_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure cycle %0d: got out_valid=%b in_ready=%b S=%h C_out=%b want 1 0 %h 0",
                 i, out_valid, in_ready, S, C_out, exp_s);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure release: got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit pulsed;
    @(negedge clk);
    A = 32'h0000_0010; B = 32'h0000_0020; C_in = 1'b0; in_valid = 1'b1;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;          // E0 accept
    in_valid = 1'b0;
    @(posedge clk); #1;          // E1, now in second RUN cycle
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || S !== 32'h0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset mid-run: got in_ready=%b busy=%b S=%h out_valid=%b want 1 0 0 0",
               in_ready, busy, S, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < NSLICE + 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) pulsed = 1'b1;
    end
    tests_run++;
    if (pulsed) begin
      tests_failed++;
      $display("FAIL reset mid-run out_valid pulse: got 1 want 0");
    end
    run_op("after_reset", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
  endtask

`ifdef ADDSEQ_SUB_EN
  task automatic test_sub();
    run_op("sub_borrow",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_no_borrow", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_run();
`ifdef ADDSEQ_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
